// File: rtl/nios2mypio_nios2_gen2_0_cpu_debug_mem_arb.sv
// Debug RAM arbiter: shares one 256x32 single-port RAM between the
// JTAG debug path (one-entry pending op) and a CPU request port.
module nios2mypio_nios2_gen2_0_cpu_debug_mem_arb (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [37:0] jdo,
   input  logic        take_action_ocimem_a,
   input  logic        take_action_ocimem_b,
   input  logic        take_no_action_ocimem_a,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [7:0]  cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_ack,
   output logic [31:0] cpu_rdata,
   output logic [7:0]  ram_addr,
   output logic        ram_we,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   output logic [31:0] MonDReg,
   output logic        jtag_busy,
   output logic        jtag_ovf
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GNT_J   = 2'd1,
      GNT_C   = 2'd2,
      RD_WAIT = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        rd_j_q, rd_j_d;
   logic        last_j_q, last_j_d;
   logic        pend_q, pend_d;
   logic        pend_we_q, pend_we_d;
   logic [7:0]  pend_addr_q, pend_addr_d;
   logic [31:0] pend_wdata_q, pend_wdata_d;
   logic [7:0]  jtag_addr_q, jtag_addr_d;
   logic [31:0] mon_q, mon_d;
   logic        ovf_q, ovf_d;
   logic        busy;
   logic        jtag_done;
   logic        unused_jdo;

   assign unused_jdo = &{1'b0, jdo[37:35], jdo[2:0]};

   assign busy = pend_q
               | (state_q == GNT_J)
               | ((state_q == RD_WAIT) & rd_j_q);

   // Next-state: JTAG strobe intake, arbitration and op completion
   always_comb begin
      state_d      = state_q;
      rd_j_d       = rd_j_q;
      last_j_d     = last_j_q;
      pend_d       = pend_q;
      pend_we_d    = pend_we_q;
      pend_addr_d  = pend_addr_q;
      pend_wdata_d = pend_wdata_q;
      mon_d        = mon_q;
      ovf_d        = ovf_q;
      jtag_done    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (pend_q && (!cpu_req || !last_j_q)) begin
               state_d  = GNT_J;
               last_j_d = 1'b1;
            end else if (cpu_req) begin
               state_d  = GNT_C;
               last_j_d = 1'b0;
            end
         end
         GNT_J: begin
            if (pend_we_q) begin
               state_d   = IDLE;
               pend_d    = 1'b0;
               jtag_done = 1'b1;
            end else begin
               state_d = RD_WAIT;
               rd_j_d  = 1'b1;
            end
         end
         GNT_C: begin
            rd_j_d  = 1'b0;
            state_d = cpu_we ? IDLE : RD_WAIT;
         end
         RD_WAIT: begin
            state_d = IDLE;
            if (rd_j_q) begin
               mon_d     = ram_rdata;
               pend_d    = 1'b0;
               jtag_done = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // A busy JTAG path cannot accept a new op; it is dropped and flagged
      if (take_action_ocimem_a) begin
         ovf_d = 1'b0;
      end else if (take_action_ocimem_b || take_no_action_ocimem_a) begin
         if (busy) begin
            ovf_d = 1'b1;
         end else begin
            pend_d       = 1'b1;
            pend_we_d    = take_action_ocimem_b;
            pend_addr_d  = jtag_addr_q;
            pend_wdata_d = jdo[34:3];
         end
      end

      // A freshly loaded address overrides the post-op increment
      if (take_action_ocimem_a)
         jtag_addr_d = jdo[17:10];
      else if (jtag_done)
         jtag_addr_d = jtag_addr_q + 8'd1;
      else
         jtag_addr_d = jtag_addr_q;
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         rd_j_q       <= 1'b0;
         last_j_q     <= 1'b0;
         pend_q       <= 1'b0;
         pend_we_q    <= 1'b0;
         pend_addr_q  <= 8'd0;
         pend_wdata_q <= 32'd0;
         jtag_addr_q  <= 8'd0;
         mon_q        <= 32'd0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         rd_j_q       <= rd_j_d;
         last_j_q     <= last_j_d;
         pend_q       <= pend_d;
         pend_we_q    <= pend_we_d;
         pend_addr_q  <= pend_addr_d;
         pend_wdata_q <= pend_wdata_d;
         jtag_addr_q  <= jtag_addr_d;
         mon_q        <= mon_d;
         ovf_q        <= ovf_d;
      end
   end

   // RAM port and CPU response decode; suppressed while reset is held
   always_comb begin
      ram_addr  = 8'd0;
      ram_we    = 1'b0;
      ram_wdata = 32'd0;
      cpu_ack   = 1'b0;
      cpu_rdata = 32'd0;
      if (reset_n) begin
         unique case (state_q)
            GNT_J: begin
               ram_addr  = pend_addr_q;
               ram_we    = pend_we_q;
               ram_wdata = pend_we_q ? pend_wdata_q : 32'd0;
            end
            GNT_C: begin
               ram_addr  = cpu_addr;
               ram_we    = cpu_we;
               ram_wdata = cpu_we ? cpu_wdata : 32'd0;
               cpu_ack   = cpu_we;
            end
            RD_WAIT: begin
               if (!rd_j_q) begin
                  cpu_ack   = 1'b1;
                  cpu_rdata = ram_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   assign MonDReg   = mon_q;
   assign jtag_busy = busy;
   assign jtag_ovf  = ovf_q;

endmodule

// File: tb/tb_nios2mypio_nios2_gen2_0_cpu_debug_mem_arb.sv
// Bench for the debug RAM arbiter: behavioural RAM, CPU vector table
// with a read-data scoreboard, and hand-written JTAG corner sequences.
module tb_nios2mypio_nios2_gen2_0_cpu_debug_mem_arb;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [37:0] jdo;
   logic        take_action_ocimem_a;
   logic        take_action_ocimem_b;
   logic        take_no_action_ocimem_a;
   logic        cpu_req;
   logic        cpu_we;
   logic [7:0]  cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_ack;
   logic [31:0] cpu_rdata;
   logic [7:0]  ram_addr;
   logic        ram_we;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata = 32'd0;
   logic [31:0] MonDReg;
   logic        jtag_busy;
   logic        jtag_ovf;

   always #5 clk = ~clk;

   nios2mypio_nios2_gen2_0_cpu_debug_mem_arb dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .jdo                     (jdo),
      .take_action_ocimem_a    (take_action_ocimem_a),
      .take_action_ocimem_b    (take_action_ocimem_b),
      .take_no_action_ocimem_a (take_no_action_ocimem_a),
      .cpu_req                 (cpu_req),
      .cpu_we                  (cpu_we),
      .cpu_addr                (cpu_addr),
      .cpu_wdata               (cpu_wdata),
      .cpu_ack                 (cpu_ack),
      .cpu_rdata               (cpu_rdata),
      .ram_addr                (ram_addr),
      .ram_we                  (ram_we),
      .ram_wdata               (ram_wdata),
      .ram_rdata               (ram_rdata),
      .MonDReg                 (MonDReg),
      .jtag_busy               (jtag_busy),
      .jtag_ovf                (jtag_ovf)
   );

   logic [31:0] mem [256] = '{default: 32'h0};
   int          wr_cnt = 0;

   always @(posedge clk) begin
      if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
         wr_cnt        <= wr_cnt + 1;
      end
      ram_rdata <= mem[ram_addr];
   end

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q [$];

   typedef struct {
      logic        we;
      logic [7:0]  a;
      logic [31:0] wd;
      logic [31:0] ed;
   } vec_t;

   vec_t tbl [10];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic strobe(input int kind, input logic [37:0] d);
      jdo = d;
      take_action_ocimem_a    = (kind == 0);
      take_action_ocimem_b    = (kind == 1);
      take_no_action_ocimem_a = (kind == 2);
      tick();
      take_action_ocimem_a    = 1'b0;
      take_action_ocimem_b    = 1'b0;
      take_no_action_ocimem_a = 1'b0;
   endtask

   task automatic set_addr(input logic [7:0] a);
      strobe(0, {20'h0, a, 10'h0});
   endtask

   task automatic jwrite(input logic [7:0] ea, input logic [31:0] d);
      strobe(1, {3'b0, d, 3'b0});
      chk("jw_busy_pend", jtag_busy, 1);
      tick();
      chk("jw_ram_we", ram_we, 1);
      chk("jw_ram_addr", ram_addr, ea);
      chk("jw_ram_wdata", ram_wdata, d);
      tick();
      chk("jw_busy_done", jtag_busy, 0);
      chk("jw_mem", mem[ea], d);
   endtask

   task automatic jread(input logic [7:0] ea, input logic [31:0] ed);
      strobe(2, 38'h0);
      tick();
      chk("jr_ram_addr", ram_addr, ea);
      chk("jr_ram_we", ram_we, 0);
      tick();
      tick();
      chk("jr_mondreg", MonDReg, ed);
      chk("jr_busy_done", jtag_busy, 0);
   endtask

   task automatic cpu_xfer(input logic we, input logic [7:0] a,
                           input logic [31:0] wd, input logic [31:0] ed,
                           input int exp_lat);
      int   lat;
      logic got;
      if (!we) exp_q.push_back(ed);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = a;
      cpu_wdata = wd;
      lat = 0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         lat++;
         if (cpu_ack) got = 1'b1;
      end
      chk("cpu_ack_seen", got, 1);
      if (got && exp_lat > 0) chk("cpu_latency", lat, exp_lat);
      if (!we && exp_q.size() > 0) begin
         if (got) chk("cpu_rdata", cpu_rdata, exp_q.pop_front());
         else void'(exp_q.pop_front());
      end
      cpu_req = 1'b0;
      tick();
      chk("cpu_ack_single", cpu_ack, 0);
      if (we) chk("cpu_mem", mem[a], wd);
   endtask

   task automatic do_reset;
      reset_n = 1'b0;
      cpu_req = 1'b0;
      tick();
      tick();
      chk("rst_cpu_ack", cpu_ack, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_wdata", ram_wdata, 0);
      chk("rst_mondreg", MonDReg, 0);
      chk("rst_busy", jtag_busy, 0);
      chk("rst_ovf", jtag_ovf, 0);
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w0;
      jdo = 38'h0;
      take_action_ocimem_a    = 1'b0;
      take_action_ocimem_b    = 1'b0;
      take_no_action_ocimem_a = 1'b0;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = 8'h0;
      cpu_wdata = 32'h0;

      tbl[0] = '{1'b1, 8'h00, 32'h1111_1111, 32'h0};
      tbl[1] = '{1'b1, 8'h20, 32'hCAFE_F00D, 32'h0};
      tbl[2] = '{1'b1, 8'h80, 32'hA5A5_A5A5, 32'h0};
      tbl[3] = '{1'b1, 8'hFF, 32'h5A5A_5A5A, 32'h0};
      tbl[4] = '{1'b0, 8'h20, 32'h0, 32'hCAFE_F00D};
      tbl[5] = '{1'b0, 8'h80, 32'h0, 32'hA5A5_A5A5};
      tbl[6] = '{1'b0, 8'hFF, 32'h0, 32'h5A5A_5A5A};
      tbl[7] = '{1'b1, 8'h80, 32'h0000_0001, 32'h0};
      tbl[8] = '{1'b0, 8'h80, 32'h0, 32'h0000_0001};
      tbl[9] = '{1'b0, 8'h00, 32'h0, 32'h1111_1111};

      do_reset();
      tick();

      for (int i = 0; i < 10; i++)
         cpu_xfer(tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].ed,
                  tbl[i].we ? 1 : 2);

      // write at 0x10, reload 0x10, read back, then confirm increment
      set_addr(8'h10);
      jwrite(8'h10, 32'hDEAD_BEEF);
      set_addr(8'h10);
      jread(8'h10, 32'hDEAD_BEEF);
      jwrite(8'h11, 32'h0000_0011);

      // address wrap 0xFF -> 0x00
      set_addr(8'hFF);
      jwrite(8'hFF, 32'h0F0F_0F0F);
      jwrite(8'h00, 32'h1111_1111);

      // back-to-back write strobes: second dropped
      set_addr(8'h50);
      w0 = wr_cnt;
      strobe(1, {3'b0, 32'h0000_AAAA, 3'b0});
      strobe(1, {3'b0, 32'h0000_BBBB, 3'b0});
      tick();
      tick();
      tick();
      chk("ovf_set", jtag_ovf, 1);
      chk("ovf_one_write", wr_cnt - w0, 1);
      chk("ovf_mem", mem[8'h50], 32'h0000_AAAA);
      set_addr(8'h60);
      chk("ovf_clear", jtag_ovf, 0);

      // address load in the completion cycle of a read
      set_addr(8'h05);
      jwrite(8'h05, 32'h1234_5678);
      set_addr(8'h05);
      strobe(2, 38'h0);
      tick();
      chk("cmp_rd_addr", ram_addr, 8'h05);
      tick();
      strobe(0, {20'h0, 8'h40, 10'h0});
      chk("cmp_mondreg", MonDReg, 32'h1234_5678);
      jwrite(8'h40, 32'h4040_4040);

      // tie right after reset: JTAG first
      do_reset();
      strobe(2, 38'h0);
      exp_q.push_back(32'hCAFE_F00D);
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 8'h20;
      tick();
      chk("tie1_jtag_addr", ram_addr, 8'h00);
      chk("tie1_no_ack", cpu_ack, 0);
      tick();
      chk("tie1_no_ack_rw", cpu_ack, 0);
      tick();
      chk("tie1_mondreg", MonDReg, 32'h1111_1111);
      tick();
      chk("tie1_cpu_addr", ram_addr, 8'h20);
      tick();
      chk("tie1_cpu_ack", cpu_ack, 1);
      chk("tie1_cpu_rdata", cpu_rdata, exp_q.pop_front());
      cpu_req = 1'b0;
      tick();

      // JTAG granted last, so the next tie goes to the CPU
      jwrite(8'h01, 32'h0BAD_F00D);
      strobe(1, {3'b0, 32'h7777_7777, 3'b0});
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = 8'h30;
      cpu_wdata = 32'h3030_3030;
      tick();
      chk("tie2_cpu_first", ram_addr, 8'h30);
      chk("tie2_cpu_ack", cpu_ack, 1);
      cpu_req = 1'b0;
      tick();
      tick();
      chk("tie2_jtag_addr", ram_addr, 8'h02);
      chk("tie2_jtag_wdata", ram_wdata, 32'h7777_7777);
      tick();
      chk("tie2_mem_cpu", mem[8'h30], 32'h3030_3030);

      // reset during a CPU read wait state
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 8'h20;
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      chk("rst_rw_no_ack", cpu_ack, 0);
      tick();
      cpu_req = 1'b0;
      chk("rst_rw_ack", cpu_ack, 0);
      chk("rst_rw_rdata", cpu_rdata, 0);
      chk("rst_rw_ram_addr", ram_addr, 0);
      chk("rst_rw_busy", jtag_busy, 0);
      chk("rst_rw_mondreg", MonDReg, 0);
      reset_n = 1'b1;
      tick();
      cpu_xfer(1'b1, 8'h33, 32'h3333_3333, 32'h0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
